// File: rtl/gba_sound_dsfifo_pkg.sv
// Shared constants and types for the GBA DirectSound FIFO channels.
package gba_sound_dsfifo_pkg;
  localparam logic [27:0] FIFO_A_ADR = 28'h40000A0;
  localparam logic [27:0] FIFO_B_ADR = 28'h40000A4;
  localparam int          DMA_THRESH = 4;  // refill request once at or below this many words

  typedef struct packed {
    logic        vld;
    logic [31:0] data;
  } fifo_push_t;
endpackage

// File: rtl/gba_dsfifo_mem.sv
// Word FIFO storage with pointer/count tracking; clear has priority over push/pop.
module gba_dsfifo_mem #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic [DEPTH_LOG2-1:0] wr_ptr,
  output logic [DEPTH_LOG2-1:0] rd_ptr,
  output logic                  full,
  output logic                  empty,
  output logic                  push_ok
);
  localparam int                    DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_MAX = DEPTH[DEPTH_LOG2:0];

  logic [DEPTH-1:0][31:0] mem;
  logic                   pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/gba_sound_dsfifo.sv
// DirectSound FIFO channel: bus push decode, halfword assembly, per-tick byte playback, DMA refill pulses.
module gba_sound_dsfifo
  import gba_sound_dsfifo_pkg::*;
#(
  parameter int          index      = 0,
  parameter logic [27:0] FIFO_ADR   = FIFO_A_ADR,
  parameter int          DEPTH_LOG2 = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                gb_on,
  input  logic [31:0]         gb_bus_din,
  input  logic [27:0]         gb_bus_adr,
  input  logic                gb_bus_rnw,
  input  logic                gb_bus_ena,
  input  logic [3:0]          gb_bus_be,
  input  logic                timer_sel,
  input  logic                fifo_reset,
  input  logic                tick0,
  input  logic                tick1,
  output logic [7:0]          sample_out,
  output logic                sample_valid,
  output logic                dma_req,
  output logic [DEPTH_LOG2:0] fill_level,
  output logic                underrun,
  output logic                overflow,
  output logic [31:0]         debugout
);
  localparam logic [DEPTH_LOG2:0] CNT_ONE = 1;
  localparam logic [DEPTH_LOG2:0] THRESH  = DMA_THRESH[DEPTH_LOG2:0];

  fifo_push_t              push;
  logic                    bus_wr, play_tick, pop, push_ok, full, empty;
  logic [31:0]             rdata;
  logic [DEPTH_LOG2:0]     count, cnt_after;
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [1:0]              byte_idx;
  logic [15:0]             hold;
  logic                    hold_v;
  logic [7:0]              cur_byte;

  assign bus_wr    = gb_bus_ena & ~gb_bus_rnw & (gb_bus_adr == FIFO_ADR);
  assign play_tick = gb_on & (timer_sel ? tick1 : tick0);
  assign pop       = play_tick & ~empty & (byte_idx == 2'd3);
  assign cur_byte  = rdata[{byte_idx, 3'b000} +: 8];
  assign cnt_after = count - CNT_ONE + (DEPTH_LOG2+1)'(push_ok);

  always_comb begin
    push.vld  = 1'b0;
    push.data = gb_bus_din;
    if (bus_wr) begin
      case (gb_bus_be)
        4'hF: push.vld = 1'b1;
        4'hC: begin
          push.vld  = 1'b1;
          push.data = {gb_bus_din[31:16], hold_v ? hold : 16'h0000};
        end
        default: push.vld = 1'b0;
      endcase
    end
  end

  gba_dsfifo_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk     (clk),
    .reset   (reset),
    .clr     (fifo_reset),
    .push    (push.vld),
    .pop     (pop),
    .wdata   (push.data),
    .rdata   (rdata),
    .count   (count),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr),
    .full    (full),
    .empty   (empty),
    .push_ok (push_ok)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx     <= '0;
      sample_out   <= '0;
      hold         <= '0;
      hold_v       <= 1'b0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
      overflow     <= 1'b0;
      dma_req      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
      overflow     <= 1'b0;
      dma_req      <= 1'b0;
      if (fifo_reset) begin
        byte_idx   <= '0;
        sample_out <= '0;
        hold_v     <= 1'b0;
      end else begin
        if (play_tick) begin
          if (empty) begin
            underrun <= 1'b1;
          end else begin
            sample_out   <= cur_byte;
            sample_valid <= 1'b1;
            byte_idx     <= byte_idx + 2'd1;
          end
        end
        overflow <= push.vld & ~push_ok;
        dma_req  <= pop & (cnt_after <= THRESH);
        if (bus_wr && gb_bus_be == 4'h3) begin
          hold   <= gb_bus_din[15:0];
          hold_v <= 1'b1;
        end else if (bus_wr && gb_bus_be == 4'hC) begin
          hold_v <= 1'b0;
        end
      end
    end
  end

  assign fill_level = count;
  assign debugout   = {1'(index), 3'b000, fill_level, byte_idx, wr_ptr, rd_ptr, sample_out, 8'h00};
endmodule

// File: doc/gba_sound_dsfifo.md
Name: gba_sound_dsfifo

Overview:
DirectSound FIFO channel (A or B) that consumes the overflow ticks produced by the timer modules. The CPU or DMA writes packed 8-bit PCM into an 8-word FIFO over the GBA register bus. Each selected timer tick plays one signed byte to the sound mixer. When the FIFO drains to half, the block raises a one-cycle DMA request so the sound DMA channel refills it with a 4-word burst.

Parameters:
index, 0, channel select (0 = FIFO A, 1 = FIFO B); used only for the debug tag.
FIFO_ADR, 28'h40000A0, bus word address of this channel's FIFO register (FIFO B instance uses 28'h40000A4).
DEPTH_LOG2, 3, log2 of FIFO depth in 32-bit words (8 words = 32 samples).

Ports:
clk  in  1  system clock, 16.7 MHz
reset  in  1  asynchronous, active-high reset
gb_on  in  1  core run enable; when low, ticks are ignored (bus writes still accepted)
gb_bus_din  in  32  bus write data
gb_bus_adr  in  28  bus address
gb_bus_rnw  in  1  1 = read, 0 = write
gb_bus_ena  in  1  bus access strobe, one cycle
gb_bus_be  in  4  byte enables
timer_sel  in  1  SOUNDCNT_H timer select (0 = tick0, 1 = tick1)
fifo_reset  in  1  SOUNDCNT_H FIFO-reset write pulse
tick0  in  1  timer 0 overflow pulse
tick1  in  1  timer 1 overflow pulse
sample_out  out  8  current signed PCM sample to the mixer
sample_valid  out  1  one-cycle pulse when sample_out updates
dma_req  out  1  one-cycle refill request to the sound DMA
fill_level  out  4  FIFO occupancy in words, 0..8
underrun  out  1  one-cycle pulse on a tick taken while the FIFO is empty
overflow  out  1  one-cycle pulse when a push is dropped because the FIFO is full
debugout  out  32  {index, 3'b0, fill_level, byte_idx, wr_ptr, rd_ptr, sample_out, 8'b0}, zero-padded

Behaviour:
- Reset (async): pointers, count, byte_idx, the halfword holding register and its valid flag, and sample_out all go to 0. All pulse outputs go to 0.
- Storage: 8 x 32-bit registers, with wr_ptr and rd_ptr 3 bits each and count 4 bits. Pointers wrap modulo 8. fill_level = count.
- Push decode: requires gb_bus_ena & ~gb_bus_rnw & gb_bus_adr == FIFO_ADR.
  - be == 4'hF: push gb_bus_din.
  - be == 4'h3: store din[15:0] in hold and set hold_v; no push.
  - be == 4'hC: push {din[31:16], hold} if hold_v, else {din[31:16], 16'h0000}; clear hold_v.
  - Any other be value: ignored.
- Pop / play: play_tick = gb_on & (timer_sel ? tick1 : tick0).
  - On play_tick with count > 0: sample_out <= byte byte_idx of mem[rd_ptr]. Byte 0 is bits [7:0], little-endian.
  - Then byte_idx increments. When byte_idx == 3, the word is popped: rd_ptr+1, count-1, byte_idx <= 0.
  - sample_valid pulses in the same registered cycle as the update, one cycle after the tick.
- Empty tick: sample_out holds its previous value, underrun pulses, byte_idx is unchanged.
- DMA request: dma_req pulses in the cycle after any pop whose resulting count is <= 4. There is at most one pulse per pop.
- Full push: if count == 8 and no pop occurs in the same cycle, the word is dropped and overflow pulses.
- Simultaneous push and pop: both take effect and count is unchanged. This includes the full case, where the pop frees the slot and the push is accepted.
- fifo_reset: clears pointers, count, byte_idx, hold_v and sample_out in one cycle. It has priority over a push or pop in the same cycle and generates no dma_req.
- Reads to FIFO_ADR: no effect; the register is write-only and does not drive the bus.
- tick0 and tick1 both high: only the selected tick is used.

Decomposition:
- Shared package: FIFO_A_ADR and FIFO_B_ADR constants, and the DMA threshold constant (4 words).
- One sub-module, gba_dsfifo_mem: an 8 x 32 register array plus pointer/count logic with push, pop and clear ports, reporting count, full and empty.
- Top level: bus decode, halfword assembly, tick selection, byte sequencing and DMA/flag pulses.

Test Plan:
- Push 32'h04030201 (be=F), then 4 ticks on tick0 with timer_sel=0 -> sample_out 01, 02, 03, 04, each with a sample_valid pulse 1 cycle after its tick; fill_level 1 -> 0 after the 4th tick; dma_req pulses once.
- Push 8 words, then a 9th push -> overflow pulse, fill_level stays 8; the 9th push issued in the same cycle as a pop is accepted and fill_level stays 8.
- Halfword write be=3 with 16'hBBAA, then be=C with 16'hDDCC -> one word 32'hDDCCBBAA pushed; subsequent ticks play AA, BB, CC, DD.
- Fill to 8 words and play 16 bytes -> dma_req pulses only after the pops leaving 7, 6, 5, 4 words: 1 pulse at the 4-word level; further pops at counts 3, 2, 1, 0 each pulse again.
- Tick on an empty FIFO -> underrun pulse, sample_out unchanged; tick1 with timer_sel=0 -> no effect; gb_on=0 -> ticks ignored.
- fifo_reset asserted together with a push and a tick -> fill_level 0, sample_out 0, no dma_req; async reset mid-playback -> all outputs 0 immediately.
